prbs31_checker: RTL
===================

# prbs31_checker

Serial PRBS31 checker: the receive-side stage that consumes the one-bit x^31+x^28+1 stream produced by the team's PRBS31 generator, looped back through the pad ring. Self-synchronises by seeding its local LFSR from the incoming bits, then free-runs the LFSR and compares it bit by bit. Reports lock status, per-bit error pulses, and saturating error and bit counters. The top-level wrapper maps these onto the dedicated outputs.

## Interface
- `LOCK_CNT`, default 64: consecutive matching bits required in VERIFY before lock.
- `WINDOW`, default 1024: bits per loss-of-lock monitoring window.
- `LOSS_THRESH`, default 8: errors within one window that force loss of lock.
- `ERR_W`, default 16: error counter width.
- `clk` in 1: single clock. All state is on the rising edge.
- `rst_n` in 1: reset, asynchronous and active-low.
- `din` in 1: received serial PRBS bit.
- `din_vld` in 1: qualifies `din`. The block ignores cycles where `din_vld`=0.
- `clr` in 1: synchronous clear of `err_count` and `bit_count`.
- `locked` out 1: high while in LOCKED.
- `err_pulse` out 1: one-cycle pulse per mismatched bit while LOCKED.
- `err_count` out ERR_W: errors counted while LOCKED, saturating at all-ones.
- `bit_count` out 32: valid bits checked while LOCKED, saturating.

## Operation
- History register `h[30:0]`: `h[0]` holds the newest bit. The predicted next bit is `p = h[27] ^ h[30]`. A shift moves `h` to `{h[29:0], x}`.
- **SEED** (reset state): each valid bit shifts in `din`. A 5-bit counter counts to 31, then the FSM moves to VERIFY.
- **VERIFY**: each valid bit shifts in `din` and compares it with `p`.
  - A match increments the match counter.
  - A mismatch sends the FSM to SEED with counters cleared.
  - When the match counter reaches LOCK_CNT, the FSM goes to LOCKED if `h` ≠ 0. If `h` == 0 (stuck-at-0 input), it goes to SEED.
- **LOCKED**: each valid bit shifts in `p`, not `din`, so the LFSR free-runs and each bit error is counted exactly once.
  - A mismatch asserts `err_pulse`, increments `err_count` and increments the window error count.
  - `bit_count` increments on every valid bit.
- **Loss of lock**: a window counter counts valid bits in LOCKED.
  - If the window error count reaches LOSS_THRESH, the FSM goes to SEED.
  - On the WINDOW-th bit, both window counters reset to 0. An error on that last bit counts toward the closing window first.
- Counters stop at saturation. `clr` zeroes both counters and wins over a same-cycle increment. `clr` does not affect the FSM or `h`.
- `din_vld`=0 freezes `h`, the FSM and all counters. `err_pulse` is 0 on such cycles.

## Timing
- Reset values: `h`=0, FSM state SEED, `locked`=0, `err_pulse`=0, `err_count`=0, `bit_count`=0, and all internal counters 0.
- All outputs are registered. `err_pulse` and the counter updates appear one cycle after the offending `din` sample.
- `locked` rises one cycle after the LOCK_CNT-th matching sample. `locked` falls one cycle after the sample that reaches LOSS_THRESH.
- Minimum time to lock with continuous `din_vld`: 31 + LOCK_CNT valid bits. With defaults that is 95 cycles, with `locked` visible on cycle 96.
- `rst_n` asserted at any time clears everything immediately. After `rst_n` deasserts, the block restarts from SEED.

## Structure
- Shared package `prbs31_pkg` holds:
  - tap constants (`TAP_A`=27, `TAP_B`=30, `LEN`=31);
  - the state enum {SEED, VERIFY, LOCKED};
  - a saturating-increment function used by all counters.
- Sub-module `prbs31_loss_monitor` holds the window bit counter, window error counter and threshold compare. It outputs a single-cycle `lose_lock` to the FSM.

## Test plan
- **Clean lock and count**: generator output with `din_vld`=1 → `locked`=1 at cycle 96. After 10000 further bits: `err_count`=0 and `bit_count`=10000.
- **Single error**: one bit inverted after lock → exactly one `err_pulse`, `err_count`=1, `locked` stays 1.
- **Loss of lock**: 8 bits inverted within one 1024-bit window → `locked` drops the cycle after the 8th error. Relock follows after a further 95 clean bits.
- **Window boundary**: 7 errors in window N and 7 in window N+1 → `locked` stays 1 and `err_count`=14.
- **Stuck-at-0**: `din`=0 constantly → `locked` never asserts within 10000 cycles.
- **Clear, gap and reset**:
  - `clr` on the same cycle as an error → `err_count`=0.
  - `din_vld` toggling 1/0 → lock at the 95th valid bit.
  - `rst_n` pulsed low mid-LOCKED → all outputs 0 asynchronously.

Source files
------------

// File: rtl/prbs31_pkg.sv
// Shared PRBS31 (x^31 + x^28 + 1) definitions: tap positions, checker states
// and the saturating increment used by every counter in the checker.
package prbs31_pkg;

  localparam int TAP_A = 27;
  localparam int TAP_B = 30;
  localparam int LEN   = 31;

  typedef enum logic [1:0] {
    SEED   = 2'd0,
    VERIFY = 2'd1,
    LOCKED = 2'd2
  } state_e;

  function automatic logic [31:0] sat_inc(input logic [31:0] v, input logic [31:0] max);
    return (v >= max) ? max : v + 32'd1;
  endfunction

endpackage

// File: rtl/prbs31_loss_monitor.sv
// Per-window error tally for the locked checker; lose_lock_o is combinational
// on the sample that reaches the threshold, stalls when bit_vld_i is low.
module prbs31_loss_monitor
  import prbs31_pkg::*;
#(
  parameter int unsigned WINDOW      = 1024,
  parameter int unsigned LOSS_THRESH = 8
) (
  input  logic clk,
  input  logic rst_n,
  input  logic bit_vld_i,
  input  logic bit_err_i,
  output logic lose_lock_o
);

  localparam int WW = (WINDOW > 1) ? $clog2(WINDOW) : 1;
  localparam int EW = $clog2(LOSS_THRESH + 1);

  logic [WW-1:0] win_bit_q, win_bit_d;
  logic [EW-1:0] win_err_q, win_err_d;
  logic [EW-1:0] err_next;
  logic          last_bit;

  always_comb begin
    err_next    = bit_err_i ? EW'(sat_inc(32'(win_err_q), LOSS_THRESH)) : win_err_q;
    last_bit    = (32'(win_bit_q) == WINDOW - 1);
    // The closing bit's own error is judged against the closing window.
    lose_lock_o = bit_vld_i && (32'(err_next) >= LOSS_THRESH);
    win_bit_d   = win_bit_q;
    win_err_d   = win_err_q;
    if (bit_vld_i) begin
      if (lose_lock_o || last_bit) begin
        win_bit_d = '0;
        win_err_d = '0;
      end else begin
        win_bit_d = WW'(32'(win_bit_q) + 32'd1);
        win_err_d = err_next;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      win_bit_q <= '0;
      win_err_q <= '0;
    end else begin
      win_bit_q <= win_bit_d;
      win_err_q <= win_err_d;
    end
  end

endmodule

// File: rtl/prbs31_checker.sv
// Self-synchronising serial PRBS31 checker with lock FSM and saturating counters.
// All outputs registered, one cycle after the sample; din_vld=0 freezes everything.
module prbs31_checker
  import prbs31_pkg::*;
#(
  parameter int unsigned LOCK_CNT    = 64,
  parameter int unsigned WINDOW      = 1024,
  parameter int unsigned LOSS_THRESH = 8,
  parameter int unsigned ERR_W       = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             din,
  input  logic             din_vld,
  input  logic             clr,
  output logic             locked,
  output logic             err_pulse,
  output logic [ERR_W-1:0] err_count,
  output logic [31:0]      bit_count
);

  localparam int MW = $clog2(LOCK_CNT + 1);
  localparam logic [31:0] ERR_MAX = (ERR_W >= 32) ? 32'hFFFF_FFFF
                                                  : 32'((64'd1 << ERR_W) - 64'd1);

  state_e           state_q, state_d;
  logic [LEN-1:0]   h_q, h_d;
  logic [4:0]       seed_q, seed_d;
  logic [MW-1:0]    match_q, match_d;
  logic [ERR_W-1:0] err_cnt_q, err_cnt_d;
  logic [31:0]      bit_cnt_q, bit_cnt_d;
  logic             err_pulse_q, err_pulse_d;

  logic             pred;
  logic             mism;
  logic [LEN-1:0]   h_din;
  logic [LEN-1:0]   h_pred;
  logic             lose_lock;

  assign pred   = h_q[TAP_A] ^ h_q[TAP_B];
  assign mism   = din ^ pred;
  assign h_din  = {h_q[LEN-2:0], din};
  assign h_pred = {h_q[LEN-2:0], pred};

  prbs31_loss_monitor #(
    .WINDOW      (WINDOW),
    .LOSS_THRESH (LOSS_THRESH)
  ) u_loss_monitor (
    .clk         (clk),
    .rst_n       (rst_n),
    .bit_vld_i   (din_vld && (state_q == LOCKED)),
    .bit_err_i   (mism),
    .lose_lock_o (lose_lock)
  );

  always_comb begin
    state_d     = state_q;
    h_d         = h_q;
    seed_d      = seed_q;
    match_d     = match_q;
    err_cnt_d   = err_cnt_q;
    bit_cnt_d   = bit_cnt_q;
    err_pulse_d = 1'b0;
    if (din_vld) begin
      unique case (state_q)
        SEED: begin
          h_d = h_din;
          if (seed_q == 5'(LEN - 1)) begin
            seed_d  = '0;
            state_d = VERIFY;
          end else begin
            seed_d = seed_q + 5'd1;
          end
        end
        VERIFY: begin
          h_d = h_din;
          if (mism) begin
            state_d = SEED;
            seed_d  = '0;
            match_d = '0;
          end else if (32'(match_q) + 32'd1 >= LOCK_CNT) begin
            match_d = '0;
            // An all-zero history is the stuck-at-0 fixed point, not a real lock.
            state_d = (h_din != '0) ? LOCKED : SEED;
          end else begin
            match_d = MW'(32'(match_q) + 32'd1);
          end
        end
        LOCKED: begin
          h_d       = h_pred;
          bit_cnt_d = sat_inc(bit_cnt_q, 32'hFFFF_FFFF);
          if (mism) begin
            err_pulse_d = 1'b1;
            err_cnt_d   = ERR_W'(sat_inc(32'(err_cnt_q), ERR_MAX));
          end
          if (lose_lock) state_d = SEED;
        end
        default: state_d = SEED;
      endcase
    end
    if (clr) begin
      err_cnt_d = '0;
      bit_cnt_d = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= SEED;
      h_q         <= '0;
      seed_q      <= '0;
      match_q     <= '0;
      err_cnt_q   <= '0;
      bit_cnt_q   <= '0;
      err_pulse_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      h_q         <= h_d;
      seed_q      <= seed_d;
      match_q     <= match_d;
      err_cnt_q   <= err_cnt_d;
      bit_cnt_q   <= bit_cnt_d;
      err_pulse_q <= err_pulse_d;
    end
  end

  assign locked    = (state_q == LOCKED);
  assign err_pulse = err_pulse_q;
  assign err_count = err_cnt_q;
  assign bit_count = bit_cnt_q;

endmodule
